// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control block for the iterative AES-128 round datapath. The CPU loads the
//   key and plaintext through a 16-bit register window and then writes start.
//   The block performs the initial AddRoundKey itself. It then issues
//   NUM_ROUNDS req/ack transactions to the external round datapath, supplying
//   Rcon and a final-round flag with each one. At the end it latches the
//   ciphertext for readback and sets a sticky done flag.
//
// Ports
//   clk_i, reset            clock, asynchronous active-high reset
//   cpu_wr_en_i/rd_en_i     register window write/read strobes
//   cpu_addr_i, cpu_wdata_i word address and write data
//   cpu_rdata_o             registered read data (1-cycle latency)
//   busy_o, done_o          encryption in progress / sticky completion
//   dp_req_o .. dp_final_o  round request and operands to the datapath
//   dp_ack_i, dp_state_i,   datapath result handshake, next state and
//   dp_key_i                next round key
//
// Register map (word n of a 128-bit value = bits [127-16n -: 16])
//   0-7 key, 8-15 plaintext, 16 control (bit0 start, reads 0),
//   17 status {14'b0, done, busy}, 24-31 result. All other words read 0.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int ADDR_W     = 5
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              cpu_wr_en_i,
    input  logic              cpu_rd_en_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [15:0]       cpu_wdata_i,
    output logic [15:0]       cpu_rdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              dp_req_o,
    output logic [127:0]      dp_state_o,
    output logic [127:0]      dp_key_o,
    output logic [7:0]        dp_rcon_o,
    output logic              dp_final_o,
    input  logic              dp_ack_i,
    input  logic [127:0]      dp_state_i,
    input  logic [127:0]      dp_key_i
);
    localparam int CNT_W  = $clog2(NUM_ROUNDS + 1);
    localparam int PAGE_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDKEY = 2'd1,
        ROUND  = 2'd2
    } fsm_t;

    fsm_t fsm_reg, fsm_next;

    logic [127:0]     key_reg, pt_reg, state_reg, rkey_reg, result_reg;
    logic [7:0]       rcon_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;
    logic [15:0]      rdata_reg;

    // Address decode: the address splits into an 8-word page and a word index.
    logic [2:0]        word_sel;
    logic [PAGE_W-1:0] page;
    logic [6:0]        word_msb;
    logic              sel_key, sel_pt, sel_res, sel_ctrl, sel_stat;

    assign word_sel = cpu_addr_i[2:0];
    assign page     = cpu_addr_i[ADDR_W-1:3];
    // 127 - 16*n == {~n, 4'hF} for a 3-bit word index n
    assign word_msb = {~word_sel, 4'hF};
    assign sel_key  = (page == PAGE_W'(0));
    assign sel_pt   = (page == PAGE_W'(1));
    assign sel_res  = (page == PAGE_W'(3));
    assign sel_ctrl = (cpu_addr_i == ADDR_W'(16));
    assign sel_stat = (cpu_addr_i == ADDR_W'(17));

    logic cfg_wr, start_accept, last_round, ack_taken;
    logic [7:0] rcon_xtime;

    // Configuration writes (including start) are only honoured while idle.
    assign cfg_wr       = cpu_wr_en_i && (fsm_reg == IDLE);
    assign start_accept = cfg_wr && sel_ctrl && cpu_wdata_i[0];
    assign last_round   = (cnt_reg == CNT_W'(NUM_ROUNDS));
    assign ack_taken    = (fsm_reg == ROUND) && dp_ack_i;
    assign rcon_xtime   = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1B : 8'h00);

    // 16-bit word views of the readable 128-bit registers
    logic [15:0] key_words [8];
    logic [15:0] pt_words  [8];
    logic [15:0] res_words [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_words
            assign key_words[gi] = key_reg[127-16*gi -: 16];
            assign pt_words[gi]  = pt_reg[127-16*gi -: 16];
            assign res_words[gi] = result_reg[127-16*gi -: 16];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // FSM next state
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:    if (start_accept) fsm_next = ADDKEY;
            ADDKEY:  fsm_next = ROUND;
            ROUND:   if (dp_ack_i && last_round) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Key and plaintext registers
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            key_reg <= '0;
            pt_reg  <= '0;
        end else if (cfg_wr) begin
            if (sel_key) key_reg[word_msb -: 16] <= cpu_wdata_i;
            if (sel_pt)  pt_reg[word_msb -: 16]  <= cpu_wdata_i;
        end
    end

    // Cipher state, round key, Rcon, round counter, result and done
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_reg  <= '0;
            rkey_reg   <= '0;
            rcon_reg   <= 8'h01;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            if (start_accept) begin
                done_reg <= 1'b0;
            end
            if (fsm_reg == ADDKEY) begin
                state_reg <= pt_reg ^ key_reg;
                rkey_reg  <= key_reg;
                cnt_reg   <= CNT_W'(1);
                rcon_reg  <= 8'h01;
            end
            if (ack_taken) begin
                state_reg <= dp_state_i;
                rkey_reg  <= dp_key_i;
                rcon_reg  <= rcon_xtime;
                if (last_round) begin
                    result_reg <= dp_state_i;
                    done_reg   <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Read mux. It reads the pre-edge values, so a read and a write to the
    // same word in the same cycle return the old contents.
    logic [15:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (sel_key)       rd_word = key_words[word_sel];
        else if (sel_pt)   rd_word = pt_words[word_sel];
        else if (sel_res)  rd_word = res_words[word_sel];
        else if (sel_stat) rd_word = {14'b0, done_reg, busy_o};
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (cpu_rd_en_i) begin
            rdata_reg <= rd_word;
        end
    end

    // dp_req_o decodes directly from the FSM register, so an asynchronous
    // reset drops it without waiting for an edge.
    assign busy_o      = (fsm_reg != IDLE);
    assign done_o      = done_reg;
    assign dp_req_o    = (fsm_reg == ROUND);
    assign dp_final_o  = dp_req_o && last_round;
    assign dp_state_o  = state_reg;
    assign dp_key_o    = rkey_reg;
    assign dp_rcon_o   = rcon_reg;
    assign cpu_rdata_o = rdata_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer. It contains a behavioural AES-128 round
// datapath with a configurable ack delay, and a full-cipher reference model
// that checks the ciphertext. It runs directed scenarios followed by
// randomized key/plaintext runs.
module tb_aes_round_sequencer;
    logic         clk_i = 1'b0;
    logic         reset;
    logic         cpu_wr_en_i, cpu_rd_en_i;
    logic [4:0]   cpu_addr_i;
    logic [15:0]  cpu_wdata_i, cpu_rdata_o;
    logic         busy_o, done_o, dp_req_o, dp_final_o;
    logic [127:0] dp_state_o, dp_key_o;
    logic [7:0]   dp_rcon_o;
    logic         dp_ack_i = 1'b0;
    logic [127:0] dp_state_i = '0, dp_key_i = '0;

    always #5 clk_i = ~clk_i;

    aes_round_sequencer #(.NUM_ROUNDS(10), .ADDR_W(5)) dut (
        .clk_i(clk_i), .reset(reset),
        .cpu_wr_en_i(cpu_wr_en_i), .cpu_rd_en_i(cpu_rd_en_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
        .busy_o(busy_o), .done_o(done_o),
        .dp_req_o(dp_req_o), .dp_state_o(dp_state_o), .dp_key_o(dp_key_o),
        .dp_rcon_o(dp_rcon_o), .dp_final_o(dp_final_o),
        .dp_ack_i(dp_ack_i), .dp_state_i(dp_state_i), .dp_key_i(dp_key_i)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [7:0] RCON_TBL [10] =
        '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox [256];

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box entry = affine transform of the multiplicative inverse in GF(2^8)
    function automatic logic [7:0] sbox_entry(input int x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sbox[w3[23:16]] ^ rc, sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) b[k] = sbox[s[127-8*k -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = t[k];
        return o ^ rk;
    endfunction

    // Whole-cipher reference: AddRoundKey followed by ten rounds with tabled Rcon
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s, rk;
        s = pt ^ key;
        rk = key;
        for (int r = 0; r < 10; r++) begin
            rk = next_key(rk, RCON_TBL[r]);
            s = aes_round(s, rk, r == 9);
        end
        return s;
    endfunction

    // ---------------- round datapath model ----------------
    int ack_delay = 0;
    int wait_cnt = 0;
    int unstable_cnt = 0;
    logic [7:0] rcon_seen [$];
    logic fin_seen [$];
    logic [127:0] lat_state, lat_key;
    logic [7:0] lat_rcon;

    always @(negedge clk_i) begin
        dp_key_i = next_key(dp_key_o, dp_rcon_o);
        dp_state_i = aes_round(dp_state_o, next_key(dp_key_o, dp_rcon_o), dp_final_o);
        if (!dp_req_o) begin
            dp_ack_i = 1'b0;
            wait_cnt = 0;
        end else begin
            if (dp_ack_i) wait_cnt = 0;  // previous request completed on the last edge
            if (wait_cnt == 0) begin
                lat_state = dp_state_o;
                lat_key = dp_key_o;
                lat_rcon = dp_rcon_o;
            end else if (dp_state_o !== lat_state || dp_key_o !== lat_key ||
                         dp_rcon_o !== lat_rcon) begin
                unstable_cnt++;
            end
            if (wait_cnt == ack_delay) begin
                dp_ack_i = 1'b1;
                rcon_seen.push_back(dp_rcon_o);
                fin_seen.push_back(dp_final_o);
            end else begin
                dp_ack_i = 1'b0;
                wait_cnt++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input int a, input logic [15:0] d);
        cpu_wr_en_i = 1'b1;
        cpu_addr_i = 5'(a);
        cpu_wdata_i = d;
        @(posedge clk_i); #1;
        cpu_wr_en_i = 1'b0;
    endtask

    task automatic cpu_read(input int a, output logic [15:0] d);
        cpu_rd_en_i = 1'b1;
        cpu_addr_i = 5'(a);
        @(posedge clk_i); #1;
        cpu_rd_en_i = 1'b0;
        d = cpu_rdata_o;
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] p);
        for (int i = 0; i < 8; i++) cpu_write(i, k[127-16*i -: 16]);
        for (int i = 0; i < 8; i++) cpu_write(8 + i, p[127-16*i -: 16]);
    endtask

    task automatic start_run();
        rcon_seen.delete();
        fin_seen.delete();
        cpu_write(16, 16'h0001);
    endtask

    // Counts edges until busy drops, giving up after 200.
    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (busy_o && cyc < 200) begin
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic read_result(output logic [127:0] r);
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            cpu_read(24 + i, w);
            r[127-16*i -: 16] = w;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rd, acc;
        logic [127:0] res, k, p;
        int cyc, d, idx;
        logic [15:0] nv;

        reset = 1'b1;
        cpu_wr_en_i = 1'b0;
        cpu_rd_en_i = 1'b0;
        cpu_addr_i = '0;
        cpu_wdata_i = '0;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_entry(x);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 128'(dp_req_o), 128'(0));
        check("rst_busy_done", 128'({busy_o, done_o, dp_final_o}), 128'(0));
        check("rst_rcon", 128'(dp_rcon_o), 128'(8'h01));
        check("rst_state_key", dp_state_o | dp_key_o, 128'(0));
        reset = 1'b0;
        @(posedge clk_i); #1;
        check("rst_rdata", 128'(cpu_rdata_o), 128'(0));

        // FIPS-197 vector, datapath acking in the same cycle
        ack_delay = 0;
        load(FIPS_KEY, FIPS_PT);
        start_run();
        check("fips_busy_start", 128'(busy_o), 128'(1));
        run_to_done(cyc);
        $display("[TB] fips run: %0d busy cycles", cyc);
        check("fips_cycles", 128'(cyc), 128'(11));
        check("fips_done", 128'(done_o), 128'(1));
        read_result(res);
        check("fips_ct", res, FIPS_CT);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rcon_%0d", i),
                  128'((i < rcon_seen.size()) ? rcon_seen[i] : 8'hxx), 128'(RCON_TBL[i]));
            check($sformatf("final_%0d", i),
                  128'((i < fin_seen.size()) ? fin_seen[i] : 1'bx), 128'(i == 9));
        end
        cpu_read(17, rd);
        check("status_done", 128'(rd), 128'(16'h0002));
        cpu_read(16, rd);
        check("ctrl_reads_zero", 128'(rd), 128'(0));
        cpu_write(20, 16'hABCD);
        cpu_read(20, rd);
        check("unmapped_zero", 128'(rd), 128'(0));
        cpu_read(8, rd);
        check("pt_word0", 128'(rd), 128'(16'h3243));

        // Handshake stall: ack three cycles after each request
        ack_delay = 3;
        unstable_cnt = 0;
        start_run();
        check("stall_done_clr", 128'(done_o), 128'(0));
        run_to_done(cyc);
        $display("[TB] stall run: %0d busy cycles", cyc);
        check("stall_cycles", 128'(cyc), 128'(41));
        check("stall_stable", 128'(unstable_cnt), 128'(0));
        read_result(res);
        check("stall_ct", res, FIPS_CT);
        ack_delay = 0;

        // Busy lockout: key write and restart mid-run are both ignored
        start_run();
        cpu_write(0, 16'hFFFF);
        cpu_write(16, 16'h0001);
        cpu_read(17, rd);
        check("lock_status_busy", 128'(rd), 128'(16'h0001));
        run_to_done(cyc);
        check("lock_cycles", 128'(cyc), 128'(8));
        read_result(res);
        check("lock_ct", res, FIPS_CT);
        cpu_read(17, rd);
        check("lock_status_done", 128'(rd), 128'(16'h0002));
        cpu_read(0, rd);
        check("lock_key0", 128'(rd), 128'(16'h2b7e));

        // Back-to-back restart without reloading
        start_run();
        check("b2b_done_clr", 128'({done_o, busy_o}), 128'(2'b01));
        run_to_done(cyc);
        check("b2b_cycles", 128'(cyc), 128'(11));
        read_result(res);
        check("b2b_ct", res, FIPS_CT);

        // Reset during round 5
        start_run();
        repeat (5) @(posedge clk_i);
        #1;
        check("mid_req_active", 128'({dp_req_o, dp_rcon_o}), 128'({1'b1, 8'h10}));
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", 128'({dp_req_o, busy_o, done_o}), 128'(0));
        #2;
        reset = 1'b0;
        @(posedge clk_i); #1;
        check("mid_rst_rcon", 128'(dp_rcon_o), 128'(8'h01));
        acc = '0;
        for (int a = 0; a < 32; a++) begin
            cpu_read(a, rd);
            acc = acc | rd;
        end
        check("mid_rst_regs_zero", 128'(acc), 128'(0));
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        load(k, p);
        start_run();
        run_to_done(cyc);
        check("post_rst_cycles", 128'(cyc), 128'(11));
        read_result(res);
        check("post_rst_ct", res, aes_ref(k, p));

        // Randomized runs with random ack delay and a same-cycle read/write
        for (int n = 0; n < 4; n++) begin
            d = int'($urandom_range(0, 2));
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            load(k, p);
            idx = int'($urandom_range(0, 15));
            nv = 16'($urandom);
            cpu_wr_en_i = 1'b1;
            cpu_rd_en_i = 1'b1;
            cpu_addr_i = 5'(idx);
            cpu_wdata_i = nv;
            @(posedge clk_i); #1;
            cpu_wr_en_i = 1'b0;
            cpu_rd_en_i = 1'b0;
            if (idx < 8) begin
                check($sformatf("rw_old_%0d", n), 128'(cpu_rdata_o), 128'(k[127-16*idx -: 16]));
                k[127-16*idx -: 16] = nv;
            end else begin
                check($sformatf("rw_old_%0d", n), 128'(cpu_rdata_o), 128'(p[127-16*(idx-8) -: 16]));
                p[127-16*(idx-8) -: 16] = nv;
            end
            ack_delay = d;
            start_run();
            run_to_done(cyc);
            $display("[TB] random run %0d: delay %0d, %0d busy cycles", n, d, cyc);
            check($sformatf("rand_cycles_%0d", n), 128'(cyc), 128'(1 + 10 * (d + 1)));
            read_result(res);
            check($sformatf("rand_ct_%0d", n), res, aes_ref(k, p));
            ack_delay = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
